// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one sequential 16-bit divider among NUM_REQ requesters.
// Divide-by-zero is answered locally; other requests are issued to the divider and returned tagged.
module div_share_ctrl #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned ID_W    = 2,
    localparam int unsigned DATA_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [DATA_W*NUM_REQ-1:0]   req_dividend,
    input  logic [DATA_W*NUM_REQ-1:0]   req_divisor,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W-1:0]           rsp_quotient,
    output logic [DATA_W-1:0]           rsp_remainder,
    output logic                        rsp_dbz,
    output logic                        div_start,
    output logic [DATA_W-1:0]           div_dividend,
    output logic [DATA_W-1:0]           div_divisor,
    input  logic [DATA_W-1:0]           div_quotient,
    input  logic [DATA_W-1:0]           div_remainder,
    input  logic                        div_valid,
    output logic                        busy,
    output logic [DATA_W-1:0]           op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_ptr_nxt;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     scan_idx;
    logic [ID_W:0]       scan_sum;
    logic                grant_found;
    logic                accept;
    logic [DATA_W-1:0]   sel_dividend;
    logic [DATA_W-1:0]   sel_divisor;
    logic [DATA_W-1:0]   dividend_arr [NUM_REQ];
    logic [DATA_W-1:0]   divisor_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign dividend_arr[i] = req_dividend[i*DATA_W +: DATA_W];
        assign divisor_arr[i]  = req_divisor[i*DATA_W +: DATA_W];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign sel_dividend = dividend_arr[grant_id];
    assign sel_divisor  = divisor_arr[grant_id];
    assign accept       = (state == IDLE) && grant_found;
    assign rr_ptr_nxt   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (sel_divisor == '0) ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (div_valid) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is withheld while reset is asserted so req_ready reads zero during reset
    always_comb begin
        req_ready = '0;
        div_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_found && rst) begin
                    req_ready = NUM_REQ'(1) << grant_id;
                end
            end
            ISSUE:   div_start = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, response capture, arbitration pointer and completion count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr        <= '0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        rsp_id       <= grant_id;
                        rr_ptr       <= rr_ptr_nxt;
                        if (sel_divisor == '0) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= sel_dividend;
                            rsp_dbz       <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (div_valid) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_dbz       <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + DATA_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
